// File: rtl/sparc_exec_unit.sv
// Decode, ALU and 256-byte big-endian data memory for the SPARC-subset pipeline.
// Define DECODE_KEYWORD_EN to drive the ASCII mnemonic on keyword; otherwise it is tied to 0.
`timescale 1ns/1ps
module sparc_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] st_data,
    input  logic        en,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm_ext,
    output logic [14:0] ctrl,
    output logic [31:0] alu_y,
    output logic        alu_zf,
    output logic [31:0] mem_rdata,
    output logic [79:0] keyword
);
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_ANDN   = 4'b0101;
    localparam logic [3:0] ALU_ORN    = 4'b0110;
    localparam logic [3:0] ALU_XNOR   = 4'b0111;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1001;
    localparam logic [3:0] ALU_SRA    = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1011;
    localparam logic [3:0] ALU_PASS_A = 4'b1100;

    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [3:0]  cond;
    logic        is_nop;
    logic [31:0] sext13, sext22, sext30;

    logic [3:0]  alu_op;
    logic        alu_src, branch, call, jmpl;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        fmt_valid;
    logic [31:0] imm;

    assign op     = instr[31:30];
    assign op2    = instr[24:22];
    assign op3    = instr[24:19];
    assign cond   = instr[28:25];
    assign is_nop = (instr == 32'h0000_0000) || (instr == 32'h0100_0000);
    assign sext13 = {{19{instr[12]}}, instr[12:0]};
    assign sext22 = {{10{instr[21]}}, instr[21:0]};
    assign sext30 = {{2{instr[29]}}, instr[29:0]};

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        branch     = 1'b0;
        call       = 1'b0;
        jmpl       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_size   = 2'b00;
        mem_signed = 1'b0;
        fmt_valid  = 1'b0;
        imm        = '0;
        case (op)
            2'b01: begin
                call      = 1'b1;
                reg_write = 1'b1;
                alu_op    = ALU_PASS_A;
                imm       = sext30;
            end
            2'b00: begin
                if (is_nop) begin
                    imm = '0;
                end else if (op2 == 3'b010) begin
                    branch = 1'b1;
                    imm    = sext22;
                end else if (op2 == 3'b100) begin
                    imm       = {instr[21:0], 10'b0};
                    alu_src   = 1'b1;
                    alu_op    = ALU_PASS_B;
                    reg_write = 1'b1;
                end
            end
            2'b10: begin
                fmt_valid = 1'b1;
                case (op3)
                    6'h00, 6'h10: alu_op = ALU_ADD;
                    6'h04, 6'h14: alu_op = ALU_SUB;
                    6'h01: alu_op = ALU_AND;
                    6'h02: alu_op = ALU_OR;
                    6'h03: alu_op = ALU_XOR;
                    6'h05: alu_op = ALU_ANDN;
                    6'h06: alu_op = ALU_ORN;
                    6'h07: alu_op = ALU_XNOR;
                    6'h25: alu_op = ALU_SLL;
                    6'h26: alu_op = ALU_SRL;
                    6'h27: alu_op = ALU_SRA;
                    6'h38: jmpl   = 1'b1;
                    default: fmt_valid = 1'b0;
                endcase
                reg_write = fmt_valid & ~jmpl;
            end
            default: begin
                fmt_valid = 1'b1;
                case (op3)
                    6'h00: begin mem_read = 1'b1; mem_size = 2'b10; end
                    6'h01: begin mem_read = 1'b1; mem_size = 2'b00; end
                    6'h02: begin mem_read = 1'b1; mem_size = 2'b01; end
                    6'h09: begin mem_read = 1'b1; mem_size = 2'b00; mem_signed = 1'b1; end
                    6'h0A: begin mem_read = 1'b1; mem_size = 2'b01; mem_signed = 1'b1; end
                    6'h04: begin mem_write = 1'b1; mem_size = 2'b10; end
                    6'h05: begin mem_write = 1'b1; mem_size = 2'b00; end
                    6'h06: begin mem_write = 1'b1; mem_size = 2'b01; end
                    default: fmt_valid = 1'b0;
                endcase
                reg_write  = mem_read;
                mem_to_reg = mem_read;
            end
        endcase
        if ((op[1] == 1'b1) && fmt_valid) begin
            alu_src = instr[13];
            imm     = sext13;
        end
    end

    assign ctrl    = {mem_signed, mem_size, mem_to_reg, reg_write, mem_write, mem_read,
                      jmpl, call, branch, alu_src, alu_op};
    assign imm_ext = imm;
    assign rs1     = instr[18:14];
    assign rs2     = instr[4:0];
    assign rd      = call ? 5'd15 : instr[29:25];

    logic [31:0] alu_b;
    logic [4:0]  shamt;

    assign alu_b = alu_src ? imm : op_b;
    assign shamt = alu_b[4:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_y = op_a + alu_b;
            ALU_SUB:    alu_y = op_a - alu_b;
            ALU_AND:    alu_y = op_a & alu_b;
            ALU_OR:     alu_y = op_a | alu_b;
            ALU_XOR:    alu_y = op_a ^ alu_b;
            ALU_ANDN:   alu_y = op_a & ~alu_b;
            ALU_ORN:    alu_y = op_a | ~alu_b;
            ALU_XNOR:   alu_y = ~(op_a ^ alu_b);
            ALU_SLL:    alu_y = op_a << shamt;
            ALU_SRL:    alu_y = op_a >> shamt;
            ALU_SRA:    alu_y = $unsigned($signed(op_a) >>> shamt);
            ALU_PASS_B: alu_y = alu_b;
            ALU_PASS_A: alu_y = op_a;
            default:    alu_y = '0;
        endcase
    end

    assign alu_zf = (alu_y == 32'h0);

    // Byte index wraps mod 256; half/word accesses align down by forcing low bits.
    logic [7:0] mem [256];
    logic [7:0] addr;
    logic [7:0] rd_byte;
    logic [15:0] rd_half;

    assign addr = alu_y[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_write && en) begin
            case (mem_size)
                2'b00: mem[addr] <= st_data[7:0];
                2'b01: begin
                    mem[{addr[7:1], 1'b0}] <= st_data[15:8];
                    mem[{addr[7:1], 1'b1}] <= st_data[7:0];
                end
                default: begin
                    mem[{addr[7:2], 2'b00}] <= st_data[31:24];
                    mem[{addr[7:2], 2'b01}] <= st_data[23:16];
                    mem[{addr[7:2], 2'b10}] <= st_data[15:8];
                    mem[{addr[7:2], 2'b11}] <= st_data[7:0];
                end
            endcase
        end
    end

    assign rd_byte = mem[addr];
    assign rd_half = {mem[{addr[7:1], 1'b0}], mem[{addr[7:1], 1'b1}]};

    always_comb begin
        mem_rdata = '0;
        if (mem_read && reset) begin
            case (mem_size)
                2'b00:   mem_rdata = mem_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
                2'b01:   mem_rdata = mem_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
                default: mem_rdata = {mem[{addr[7:2], 2'b00}], mem[{addr[7:2], 2'b01}],
                                      mem[{addr[7:2], 2'b10}], mem[{addr[7:2], 2'b11}]};
            endcase
        end
    end

`ifdef DECODE_KEYWORD_EN
    always_comb begin
        keyword = "UNKNOWN   ";
        case (op)
            2'b01: keyword = "CALL      ";
            2'b00: begin
                if (is_nop) keyword = "NOP       ";
                else if (op2 == 3'b010) begin
                    case (cond)
                        4'b1000: keyword = "BA        ";
                        4'b0001: keyword = "BE        ";
                        4'b1001: keyword = "BNE       ";
                        default: keyword = "BICC      ";
                    endcase
                end else if (op2 == 3'b100) keyword = "SETHI     ";
            end
            2'b10: begin
                case (op3)
                    6'h00: keyword = "ADD       ";
                    6'h04: keyword = "SUB       ";
                    6'h01: keyword = "AND       ";
                    6'h02: keyword = "OR        ";
                    6'h03: keyword = "XOR       ";
                    6'h05: keyword = "ANDN      ";
                    6'h06: keyword = "ORN       ";
                    6'h07: keyword = "XNOR      ";
                    6'h10: keyword = "ADDCC     ";
                    6'h14: keyword = "SUBCC     ";
                    6'h25: keyword = "SLL       ";
                    6'h26: keyword = "SRL       ";
                    6'h27: keyword = "SRA       ";
                    6'h38: keyword = "JMPL      ";
                    default: keyword = "UNKNOWN   ";
                endcase
            end
            default: begin
                case (op3)
                    6'h00: keyword = "LD        ";
                    6'h01: keyword = "LDUB      ";
                    6'h02: keyword = "LDUH      ";
                    6'h09: keyword = "LDSB      ";
                    6'h0A: keyword = "LDSH      ";
                    6'h04: keyword = "ST        ";
                    6'h05: keyword = "STB       ";
                    6'h06: keyword = "STH       ";
                    default: keyword = "UNKNOWN   ";
                endcase
            end
        endcase
    end
`else
    assign keyword = '0;
`endif

endmodule

// File: tb/tb_sparc_exec_unit.sv
// Directed bench for sparc_exec_unit: mnemonic-level reference model plus literal pins.
`timescale 1ns/1ps
module tb_sparc_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, op_a, op_b, st_data;
    logic        en;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_ext, alu_y, mem_rdata;
    logic [14:0] ctrl;
    logic        alu_zf;
    logic [79:0] keyword;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mm [256];

    typedef struct packed {
        logic [14:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] y;
        logic [31:0] rdata;
        logic [79:0] kw;
        logic        st;
    } exp_t;

    sparc_exec_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .op_a(op_a), .op_b(op_b),
        .st_data(st_data), .en(en), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm_ext(imm_ext), .ctrl(ctrl), .alu_y(alu_y), .alu_zf(alu_zf),
        .mem_rdata(mem_rdata), .keyword(keyword)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        v = v & m;
        if (v[w-1]) return v | ~m;
        return v;
    endfunction

    function automatic logic [79:0] pad10(input string s);
        logic [79:0] k;
        k = {10{8'h20}};
        for (int j = 0; j < s.len() && j < 10; j++) k[79-8*j -: 8] = s[j];
        return k;
    endfunction

    function automatic string mnem(input logic [31:0] i);
        logic [5:0] o3;
        o3 = i[24:19];
        if (i[31:30] == 2'd1) return "CALL";
        if (i[31:30] == 2'd0) begin
            if (i == 32'h0 || i == 32'h0100_0000) return "NOP";
            if (i[24:22] == 3'b010) begin
                if (i[28:25] == 4'b1000) return "BA";
                if (i[28:25] == 4'b0001) return "BE";
                if (i[28:25] == 4'b1001) return "BNE";
                return "BICC";
            end
            if (i[24:22] == 3'b100) return "SETHI";
            return "UNKNOWN";
        end
        if (i[31:30] == 2'd2) begin
            case (o3)
                6'o00: return "ADD";   6'o04: return "SUB";   6'o01: return "AND";
                6'o02: return "OR";    6'o03: return "XOR";   6'o05: return "ANDN";
                6'o06: return "ORN";   6'o07: return "XNOR";  6'o20: return "ADDCC";
                6'o24: return "SUBCC"; 6'o45: return "SLL";   6'o46: return "SRL";
                6'o47: return "SRA";   6'o70: return "JMPL";
                default: return "UNKNOWN";
            endcase
        end
        case (o3)
            6'o00: return "LD";   6'o01: return "LDUB"; 6'o02: return "LDUH";
            6'o11: return "LDSB"; 6'o12: return "LDSH"; 6'o04: return "ST";
            6'o05: return "STB";  6'o06: return "STH";
            default: return "UNKNOWN";
        endcase
    endfunction

    function automatic int alu_code(input string n);
        if (n == "ADD" || n == "ADDCC") return 0;
        if (n == "SUB" || n == "SUBCC") return 1;
        if (n == "AND")  return 2;
        if (n == "OR")   return 3;
        if (n == "XOR")  return 4;
        if (n == "ANDN") return 5;
        if (n == "ORN")  return 6;
        if (n == "XNOR") return 7;
        if (n == "SLL")  return 8;
        if (n == "SRL")  return 9;
        if (n == "SRA")  return 10;
        return -1;
    endfunction

    function automatic exp_t model(input logic [31:0] i, a, bb, input logic rst);
        exp_t e;
        string n;
        int code, base;
        logic ld, st, br, src, sg;
        logic [3:0] aop;
        logic [1:0] sz;
        logic [31:0] b, y;
        n    = mnem(i);
        code = alu_code(n);
        ld = (n == "LD") || (n == "LDUB") || (n == "LDUH") || (n == "LDSB") || (n == "LDSH");
        st = (n == "ST") || (n == "STB") || (n == "STH");
        br = (n == "BA") || (n == "BE") || (n == "BNE") || (n == "BICC");
        aop = (n == "CALL") ? 4'd12 : (n == "SETHI") ? 4'd11 : (code >= 0) ? 4'(code) : 4'd0;
        src = (n == "SETHI") ? 1'b1 : (code >= 0 || n == "JMPL" || ld || st) ? i[13] : 1'b0;
        if (n == "CALL")       e.imm = sx(i, 30);
        else if (br)           e.imm = sx(i, 22);
        else if (n == "SETHI") e.imm = (i & 32'h003F_FFFF) * 1024;
        else if (code >= 0 || n == "JMPL" || ld || st) e.imm = sx(i, 13);
        else                   e.imm = 32'h0;
        sz = (n == "LD" || n == "ST") ? 2'd2 : (n == "LDUH" || n == "LDSH" || n == "STH") ? 2'd1 : 2'd0;
        sg = (n == "LDSB") || (n == "LDSH");
        e.ctrl = {sg, sz, ld, (n == "CALL" || n == "SETHI" || code >= 0 || ld), st, ld,
                  (n == "JMPL"), (n == "CALL"), br, src, aop};
        e.rd = (n == "CALL") ? 5'd15 : i[29:25];
        b = src ? e.imm : bb;
        case (aop)
            4'd0:  y = a + b;
            4'd1:  y = a - b;
            4'd2:  y = a & b;
            4'd3:  y = a | b;
            4'd4:  y = a ^ b;
            4'd5:  y = a & ~b;
            4'd6:  y = a | ~b;
            4'd7:  y = ~(a ^ b);
            4'd8:  y = a << b[4:0];
            4'd9:  y = a >> b[4:0];
            4'd10: begin
                y = a >> b[4:0];
                if (a[31]) y = y | ~(32'hFFFF_FFFF >> b[4:0]);
            end
            4'd11: y = b;
            4'd12: y = a;
            default: y = 32'h0;
        endcase
        e.y = y;
        e.st = st;
        e.rdata = 32'h0;
        if (rst && ld) begin
            base = int'(y[7:0]);
            if (sz == 2'd2) begin
                base = base - (base % 4);
                e.rdata = {mm[base], mm[base+1], mm[base+2], mm[base+3]};
            end else if (sz == 2'd1) begin
                base = base - (base % 2);
                e.rdata = {16'h0, mm[base], mm[base+1]};
                if (sg) e.rdata = sx(e.rdata, 16);
            end else begin
                e.rdata = {24'h0, mm[base]};
                if (sg) e.rdata = sx(e.rdata, 8);
            end
        end
`ifdef DECODE_KEYWORD_EN
        e.kw = pad10(n);
`else
        e.kw = 80'h0;
`endif
        return e;
    endfunction

    // Reference memory follows the same edge/reset rules as the block.
    always @(posedge clk or negedge reset) begin
        exp_t w;
        int base;
        if (!reset) begin
            for (int k = 0; k < 256; k++) mm[k] = 8'h00;
        end else begin
            w = model(instr, op_a, op_b, reset);
            if (w.st && en) begin
                base = int'(w.y[7:0]);
                if (w.ctrl[13:12] == 2'd2) begin
                    base = base - (base % 4);
                    {mm[base], mm[base+1], mm[base+2], mm[base+3]} = st_data;
                end else if (w.ctrl[13:12] == 2'd1) begin
                    base = base - (base % 2);
                    {mm[base], mm[base+1]} = st_data[15:0];
                end else begin
                    mm[base] = st_data[7:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = model(instr, op_a, op_b, reset);
        chk("rs1", rs1, instr[18:14]);
        chk("rs2", rs2, instr[4:0]);
        chk("rd", rd, e.rd);
        chk("imm_ext", imm_ext, e.imm);
        chk("ctrl", ctrl, e.ctrl);
        chk("alu_y", alu_y, e.y);
        chk("alu_zf", alu_zf, (e.y == 32'h0));
        chk("mem_rdata", mem_rdata, e.rdata);
        chk("keyword", keyword, e.kw);
    end

    function automatic logic [31:0] f3(input logic [1:0] o, input logic [4:0] d, input logic [5:0] o3,
                                       input logic [4:0] r1, input logic im, input logic [12:0] lo);
        return {o, d, o3, r1, im, lo};
    endfunction

    task automatic drive(input logic [31:0] i, a, b, s, input logic e);
        @(posedge clk);
        #1;
        instr = i; op_a = a; op_b = b; st_data = s; en = e;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic lit_kw(input string nm, input logic [79:0] k);
`ifdef DECODE_KEYWORD_EN
        chk(nm, keyword, k);
`else
        chk(nm, keyword, 80'h0);
`endif
    endtask

    logic [5:0] alu_list [14] = '{6'h00, 6'h04, 6'h01, 6'h02, 6'h03, 6'h05, 6'h06,
                                  6'h07, 6'h10, 6'h14, 6'h25, 6'h26, 6'h27, 6'h38};

    initial begin
        exp_t m;
        reset = 1'b0; instr = 32'h0; op_a = 32'h0; op_b = 32'h0; st_data = 32'h0; en = 1'b0;
        for (int k = 0; k < 256; k++) mm[k] = 8'h00;

        // Store attempted while held in reset must be dropped.
        drive(f3(2'b11, 5'd1, 6'h06, 5'd0, 1'b1, 13'h002), 32'h0, 32'h0, 32'h0000_ABCD, 1'b1);
        drive(f3(2'b11, 5'd1, 6'h02, 5'd0, 1'b1, 13'h002), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ld_in_reset", mem_rdata, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        settle;
        chk("ld_after_reset", mem_rdata, 32'h0);

        drive(32'h8200_6005, 32'd10, 32'h0, 32'h0, 1'b0);
        settle;
        chk("add_y", alu_y, 32'd15);
        chk("add_ctrl", ctrl, 15'h0410);
        chk("add_rd", rd, 5'd1);
        lit_kw("add_kw", "ADD       ");
        m = model(32'h8200_6005, 32'd10, 32'h0, 1'b1);
        chk("model_add_y", m.y, 32'd15);
        chk("model_add_ctrl", m.ctrl, 15'h0410);

        drive(f3(2'b10, 5'd3, 6'h14, 5'd2, 1'b0, 13'd3), 32'd7, 32'd7, 32'h0, 1'b0);
        settle;
        chk("subcc_y", alu_y, 32'h0);
        chk("subcc_zf", alu_zf, 1'b1);

        drive(f3(2'b10, 5'd4, 6'h27, 5'd1, 1'b1, 13'd4), 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        settle;
        chk("sra_y", alu_y, 32'hF800_0000);
        m = model(f3(2'b10, 5'd4, 6'h27, 5'd1, 1'b1, 13'd4), 32'h8000_0000, 32'h0, 1'b1);
        chk("model_sra_y", m.y, 32'hF800_0000);

        foreach (alu_list[k]) begin
            drive(f3(2'b10, 5'd5, alu_list[k], 5'd6, 1'b0, 13'd7), 32'hF0F0_1234, 32'h0FF0_0025, 32'h0, 1'b0);
            drive(f3(2'b10, 5'd5, alu_list[k], 5'd6, 1'b1, 13'h1FF3), 32'hF0F0_1234, 32'h0FF0_0025, 32'h0, 1'b0);
        end
        drive(f3(2'b10, 5'd5, 6'h38, 5'd6, 1'b1, 13'd8), 32'h100, 32'h0, 32'h0, 1'b0);
        settle;
        chk("jmpl_ctrl", ctrl, 15'h0090);

        drive(f3(2'b10, 5'd2, 6'h3F, 5'd1, 1'b1, 13'd9), 32'd5, 32'd6, 32'h0, 1'b0);
        settle;
        chk("undef_ctrl", ctrl, 15'h0);
        chk("undef_imm", imm_ext, 32'h0);
        lit_kw("undef_kw", "UNKNOWN   ");

        // STH to 0x102 lands on bytes 0x02/0x03.
        drive(f3(2'b11, 5'd1, 6'h06, 5'd0, 1'b1, 13'h102), 32'h0, 32'h0, 32'h0000_ABCD, 1'b1);
        drive(f3(2'b11, 5'd1, 6'h0A, 5'd0, 1'b1, 13'h002), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ldsh", mem_rdata, 32'hFFFF_ABCD);
        drive(f3(2'b11, 5'd1, 6'h02, 5'd0, 1'b1, 13'h002), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("lduh", mem_rdata, 32'h0000_ABCD);
        drive(f3(2'b11, 5'd1, 6'h01, 5'd0, 1'b1, 13'h003), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ldub", mem_rdata, 32'h0000_00CD);
        drive(f3(2'b11, 5'd1, 6'h09, 5'd0, 1'b1, 13'h003), 32'h0, 32'h0, 32'h0, 1'b0);
        drive(f3(2'b11, 5'd1, 6'h09, 5'd0, 1'b1, 13'h002), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ldsb", mem_rdata, 32'hFFFF_FFAB);

        drive(f3(2'b11, 5'd1, 6'h04, 5'd2, 1'b1, 13'h00C), 32'hF0, 32'h0, 32'h1122_3344, 1'b1);
        drive(f3(2'b11, 5'd1, 6'h00, 5'd2, 1'b1, 13'h000), 32'hFF, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ld_fc", mem_rdata, 32'h1122_3344);
        drive(f3(2'b11, 5'd1, 6'h04, 5'd2, 1'b1, 13'h00E), 32'hF0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        drive(f3(2'b11, 5'd1, 6'h00, 5'd2, 1'b1, 13'h000), 32'hFC, 32'h0, 32'h0, 1'b0);
        settle;
        chk("st_en0", mem_rdata, 32'h1122_3344);

        drive(f3(2'b11, 5'd1, 6'h05, 5'd2, 1'b1, 13'h001), 32'hFFFF_FFFF, 32'h0, 32'h0000_005A, 1'b1);
        drive(f3(2'b11, 5'd1, 6'h00, 5'd2, 1'b1, 13'h000), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ld_wrap", mem_rdata, 32'h5A00_ABCD);

        // Reset falls while a store is pending: store discarded, memory cleared.
        drive(f3(2'b11, 5'd1, 6'h04, 5'd2, 1'b1, 13'h000), 32'h0, 32'h0, 32'h9999_9999, 1'b1);
        #2 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        instr = f3(2'b11, 5'd1, 6'h00, 5'd2, 1'b1, 13'h000); en = 1'b0;
        settle;
        chk("ld0_post_reset", mem_rdata, 32'h0);
        drive(f3(2'b11, 5'd1, 6'h00, 5'd2, 1'b1, 13'h0FC), 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("ldfc_post_reset", mem_rdata, 32'h0);

        drive({2'b00, 1'b0, 4'b1001, 3'b010, 22'h3F_FFFF}, 32'd3, 32'd4, 32'h0, 1'b0);
        settle;
        chk("bne_ctrl", ctrl, 15'h0020);
        chk("bne_imm", imm_ext, 32'hFFFF_FFFF);
        lit_kw("bne_kw", "BNE       ");
        drive({2'b00, 1'b0, 4'b1000, 3'b010, 22'h00_0010}, 32'd3, 32'd4, 32'h0, 1'b0);
        drive({2'b00, 1'b1, 4'b0001, 3'b010, 22'h20_0000}, 32'd3, 32'd4, 32'h0, 1'b0);
        drive({2'b00, 1'b0, 4'b0101, 3'b010, 22'h00_0001}, 32'd3, 32'd4, 32'h0, 1'b0);

        drive({2'b01, 30'd4}, 32'h0000_4000, 32'h0, 32'h0, 1'b0);
        settle;
        chk("call_rd", rd, 5'd15);
        chk("call_ctrl", ctrl, 15'h044C);
        chk("call_imm", imm_ext, 32'd4);
        chk("call_y", alu_y, 32'h0000_4000);
        drive({2'b01, 30'h2000_0000}, 32'h0, 32'h0, 32'h0, 1'b0);

        drive(32'h0100_0000, 32'd1, 32'd2, 32'h0, 1'b0);
        settle;
        chk("nop_ctrl", ctrl, 15'h0);
        lit_kw("nop_kw", "NOP       ");
        drive(32'h0000_0000, 32'd1, 32'd2, 32'h0, 1'b0);
        settle;
        chk("nop0_ctrl", ctrl, 15'h0);

        drive({2'b00, 5'd3, 3'b100, 22'h12_3456}, 32'h0, 32'h0, 32'h0, 1'b0);
        settle;
        chk("sethi_imm", imm_ext, 32'h48D1_5800);
        chk("sethi_y", alu_y, 32'h48D1_5800);
        drive(32'h0000_0001, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(f3(2'b11, 5'd1, 6'h3F, 5'd2, 1'b1, 13'h010), 32'h0, 32'h0, 32'h0, 1'b1);

        @(posedge clk);
        settle;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
